// File: rtl/pe_ec_scheduler.sv
// rtl/pe_ec_scheduler.sv - request/capture/pack sequencer for one binary conv+pool+binarize PE
module pe_ec_scheduler #(
    parameter int OUT_H        = 16,
    parameter int OUT_W        = 16,
    parameter int N_CH         = 64,
    parameter int PACK_W       = 32,
    parameter int PINDEX_WIDTH = 2,
    parameter int PE_LAT       = 1,
    localparam int RW = (OUT_H  > 1) ? $clog2(OUT_H)  : 1,
    localparam int CW = (OUT_W  > 1) ? $clog2(OUT_W)  : 1,
    localparam int HW = (N_CH   > 1) ? $clog2(N_CH)   : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    output logic                             busy,
    output logic                             done,
    output logic                             req_valid,
    input  logic                             req_ready,
    output logic [RW-1:0]                    req_row,
    output logic [CW-1:0]                    req_col,
    output logic [HW-1:0]                    req_ch,
    input  logic                             pe_data,
    input  logic [PINDEX_WIDTH-1:0]          pe_pindex,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [PACK_W-1:0]                out_data,
    output logic [PACK_W*PINDEX_WIDTH-1:0]   out_pidx,
    output logic                             out_last
);

    localparam int SW = (PACK_W > 1) ? $clog2(PACK_W) : 1;
    localparam int LW = $clog2(PE_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_CAPT = 3'd3,
        S_EMIT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                            state_q, state_d;
    logic [RW-1:0]                     row_q, row_d;
    logic [CW-1:0]                     col_q, col_d;
    logic [HW-1:0]                     ch_q, ch_d;
    logic [SW-1:0]                     slot_q, slot_d;
    logic [LW-1:0]                     lat_q, lat_d;
    logic [PACK_W-1:0]                 data_q, data_d;
    logic [PACK_W*PINDEX_WIDTH-1:0]    pidx_q, pidx_d;

    logic last_pos;
    logic ch_wrap;
    logic col_wrap;

    assign ch_wrap  = (ch_q == HW'(N_CH - 1));
    assign col_wrap = (col_q == CW'(OUT_W - 1));
    assign last_pos = ch_wrap && col_wrap && (row_q == RW'(OUT_H - 1));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        ch_d    = ch_q;
        slot_d  = slot_q;
        lat_d   = lat_q;
        data_d  = data_q;
        pidx_d  = pidx_q;

        // abort outranks every handshake; in IDLE it is ignored so start wins
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            row_d   = '0;
            col_d   = '0;
            ch_d    = '0;
            slot_d  = '0;
            lat_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (req_ready) begin
                        state_d = S_WAIT;
                        lat_d   = LW'(PE_LAT);
                    end
                end
                S_WAIT: begin
                    lat_d = lat_q - LW'(1);
                    if (lat_q == LW'(1)) begin
                        state_d = S_CAPT;
                    end
                end
                S_CAPT: begin
                    data_d[slot_q] = pe_data;
                    pidx_d[int'(slot_q)*PINDEX_WIDTH +: PINDEX_WIDTH] = pe_pindex;
                    if (slot_q == SW'(PACK_W - 1)) begin
                        state_d = S_EMIT;
                    end else begin
                        ch_d    = ch_q + HW'(1);
                        slot_d  = slot_q + SW'(1);
                        state_d = S_REQ;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (last_pos) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_REQ;
                            slot_d  = '0;
                            if (ch_wrap) begin
                                ch_d = '0;
                                if (col_wrap) begin
                                    col_d = '0;
                                    row_d = row_q + RW'(1);
                                end else begin
                                    col_d = col_q + CW'(1);
                                end
                            end else begin
                                ch_d = ch_q + HW'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    row_d   = '0;
                    col_d   = '0;
                    ch_d    = '0;
                    slot_d  = '0;
                    lat_d   = '0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            ch_q    <= '0;
            slot_q  <= '0;
            lat_q   <= '0;
            data_q  <= '0;
            pidx_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ch_q    <= ch_d;
            slot_q  <= slot_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
            pidx_q  <= pidx_d;
        end
    end

    // every output is a decode of registered state, so no input reaches an output combinationally
    assign busy      = (state_q == S_REQ) || (state_q == S_WAIT) ||
                       (state_q == S_CAPT) || (state_q == S_EMIT);
    assign done      = (state_q == S_DONE);
    assign req_valid = (state_q == S_REQ);
    assign req_row   = row_q;
    assign req_col   = col_q;
    assign req_ch    = ch_q;
    assign out_valid = (state_q == S_EMIT);
    assign out_data  = data_q;
    assign out_pidx  = pidx_q;
    assign out_last  = (state_q == S_EMIT) && last_pos;

endmodule
